booth_product_divider_module: RTL
=================================

BOOTH_PRODUCT_DIVIDER_MODULE -- requirements
Module: booth_product_divider_module

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start_sig  input  1  request, level-held by master until done_sig seen.
REQ-005 dividend  input  16  signed two's-complement dividend (a multiplier product).
REQ-006 divisor  input  8  signed two's-complement divisor.
REQ-007 done_sig  output  1  one-cycle completion pulse.
REQ-008 quotient  output  8  signed quotient, truncated toward zero, saturated on overflow.
REQ-009 remainder  output  8  signed remainder; sign follows dividend; zero-magnitude gives 0.
REQ-010 overflow  output  1  true quotient outside -128..127.
REQ-011 div_zero  output  1  divisor was zero.
REQ-012 SQ_r  output  9  debug: current partial-remainder magnitude.
REQ-013 SQ_q  output  16  debug: current quotient-magnitude shift register.

Function
REQ-014 States SHALL be IDLE, DIV, FIX, WAIT.
REQ-015 In IDLE with start_sig=1 at edge E0, SHALL capture |dividend| (17-bit safe, -32768 -> 32768), |divisor|, both sign bits, result sign = XOR of signs; clear SQ_r, SQ_q, counter.
REQ-016 At E0, divisor nonzero -> DIV; divisor zero -> FIX directly.
REQ-017 DIV SHALL run exactly 16 restoring steps, one per edge (E1..E16), MSB first: shift next dividend bit into SQ_r; if SQ_r >= |divisor|, subtract and shift 1 into SQ_q, else shift 0.
REQ-018 After the 16th step (E16) SHALL enter FIX.
REQ-019 At FIX edge SHALL register quotient, remainder, overflow, div_zero, set done_sig=1, enter WAIT.
REQ-020 Normal latency: done_sig high E17..E18; divide-by-zero latency: done_sig high E1..E2.
REQ-021 Quotient sign rule: negate magnitude when result sign=1; remainder negated when dividend sign=1.
REQ-022 overflow=1 when magnitude >127 with positive result or >128 with negative result; quotient then saturates to 8'h7F / 8'h80; remainder still exact.
REQ-023 div_zero case: quotient=0, remainder=0, overflow=0, div_zero=1.
REQ-024 In WAIT, done_sig SHALL drop after one cycle; block stays in WAIT until start_sig sampled 0, then IDLE; no new request accepted before IDLE.
REQ-025 dividend/divisor/start_sig changes during DIV/FIX SHALL be ignored; only E0 values used.
REQ-026 quotient/remainder/overflow/div_zero SHALL hold their values until the next FIX edge.

Reset
REQ-027 rst=1 at any time, including mid-DIV, SHALL immediately force IDLE, counter 0, done_sig 0, quotient 0, remainder 0, overflow 0, div_zero 0, SQ_r 0, SQ_q 0.
REQ-028 After rst release, a request in progress before reset SHALL NOT resume; a held start_sig is treated as a new request.

Verification
REQ-029 dividend=8, divisor=4 -> quotient=2, remainder=0, flags 0, done_sig exactly at E0+17 for one cycle.
REQ-030 dividend=-16129 (16'hC0FF), divisor=-127 -> quotient=127, remainder=0; dividend=16129, divisor=-127 -> quotient=-127 (8'h81).
REQ-031 dividend=-7, divisor=2 -> quotient=-3 (8'hFD), remainder=-1 (8'hFF).
REQ-032 dividend=-32768, divisor=-128 -> overflow=1, quotient=8'h7F, remainder=0; dividend=32767, divisor=1 -> overflow=1, quotient=8'h7F.
REQ-033 dividend=100, divisor=0 -> div_zero=1, quotient=0, remainder=0, done_sig at E0+1.
REQ-034 rst pulse at E8 of a 8/4 run -> all outputs 0 immediately, no done_sig; start_sig held high -> fresh run completes 17 edges after first post-reset sampling edge; start_sig held high through WAIT -> no second done_sig until start_sig drops and rises again.

Source files
------------

// File: rtl/booth_product_divider_module.sv
// Signed 16/8 restoring divider: one quotient bit per clock, truncation toward zero,
// saturating 8-bit quotient, plus divide-by-zero and overflow flags.
module booth_product_divider_module (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_sig,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic        done_sig,
  output logic [7:0]  quotient,
  output logic [7:0]  remainder,
  output logic        overflow,
  output logic        div_zero,
  output logic [8:0]  SQ_r,
  output logic [15:0] SQ_q
);

  typedef enum logic [1:0] {IDLE, DIV, FIX, WAIT} state_t;

  state_t      state_q, state_d;
  logic [15:0] dvd_q, dvd_d;
  logic [7:0]  dsr_q, dsr_d;
  logic        dvd_neg_q, dvd_neg_d;
  logic        res_neg_q, res_neg_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [8:0]  sq_r_q, sq_r_d;
  logic [15:0] sq_q_q, sq_q_d;
  logic [7:0]  quotient_q, quotient_d;
  logic [7:0]  remainder_q, remainder_d;
  logic        overflow_q, overflow_d;
  logic        div_zero_q, div_zero_d;
  logic        done_q, done_d;

  // Unsigned 16/8-bit magnitudes hold the -32768 and -128 extremes without extra width.
  logic [15:0] dvd_abs;
  logic [7:0]  dsr_abs;
  logic [8:0]  shifted;
  logic        sat;

  assign dvd_abs = dividend[15] ? (~dividend + 16'd1) : dividend;
  assign dsr_abs = divisor[7]   ? (~divisor  + 8'd1)  : divisor;
  assign shifted = {sq_r_q[7:0], dvd_q[15]};
  assign sat     = res_neg_q ? (sq_q_q > 16'd128) : (sq_q_q > 16'd127);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      dvd_q       <= '0;
      dsr_q       <= '0;
      dvd_neg_q   <= 1'b0;
      res_neg_q   <= 1'b0;
      cnt_q       <= '0;
      sq_r_q      <= '0;
      sq_q_q      <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      overflow_q  <= 1'b0;
      div_zero_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      dsr_q       <= dsr_d;
      dvd_neg_q   <= dvd_neg_d;
      res_neg_q   <= res_neg_d;
      cnt_q       <= cnt_d;
      sq_r_q      <= sq_r_d;
      sq_q_q      <= sq_q_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      overflow_q  <= overflow_d;
      div_zero_q  <= div_zero_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_sig) state_d = (divisor == 8'd0) ? FIX : DIV;
      DIV:  if (cnt_q == 4'd15) state_d = FIX;
      FIX:  state_d = WAIT;
      WAIT: if (!start_sig) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dvd_d       = dvd_q;
    dsr_d       = dsr_q;
    dvd_neg_d   = dvd_neg_q;
    res_neg_d   = res_neg_q;
    cnt_d       = cnt_q;
    sq_r_d      = sq_r_q;
    sq_q_d      = sq_q_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    overflow_d  = overflow_q;
    div_zero_d  = div_zero_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_sig) begin
          dvd_d     = dvd_abs;
          dsr_d     = dsr_abs;
          dvd_neg_d = dividend[15];
          res_neg_d = dividend[15] ^ divisor[7];
          cnt_d     = '0;
          sq_r_d    = '0;
          sq_q_d    = '0;
        end
      end
      DIV: begin
        // Partial remainder stays below the divisor (<=128), so the 9-bit shift never loses data.
        dvd_d = {dvd_q[14:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (shifted >= {1'b0, dsr_q}) begin
          sq_r_d = shifted - {1'b0, dsr_q};
          sq_q_d = {sq_q_q[14:0], 1'b1};
        end else begin
          sq_r_d = shifted;
          sq_q_d = {sq_q_q[14:0], 1'b0};
        end
      end
      FIX: begin
        done_d = 1'b1;
        if (dsr_q == 8'd0) begin
          quotient_d  = '0;
          remainder_d = '0;
          overflow_d  = 1'b0;
          div_zero_d  = 1'b1;
        end else begin
          div_zero_d  = 1'b0;
          overflow_d  = sat;
          if (sat)
            quotient_d = res_neg_q ? 8'h80 : 8'h7F;
          else
            quotient_d = res_neg_q ? (~sq_q_q[7:0] + 8'd1) : sq_q_q[7:0];
          remainder_d = dvd_neg_q ? (~sq_r_q[7:0] + 8'd1) : sq_r_q[7:0];
        end
      end
      default: ;
    endcase
  end

  assign done_sig  = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign overflow  = overflow_q;
  assign div_zero  = div_zero_q;
  assign SQ_r      = sq_r_q;
  assign SQ_q      = sq_q_q;

endmodule
